// File: rtl/atb_sink.sv
`default_nettype none
// ============================================================================
// Module   : atb_sink
// Brief    : ATB slave endpoint. Buffers trace beats in a show-ahead FIFO,
//            drops and counts reserved-ID beats, issues flush requests and
//            periodic synchronisation requests toward the ATB master.
// Revision : 1.0 - initial release
// ============================================================================
module atb_sink #(
  parameter int DATA_W      = 32,
  parameter int BYTES_W     = 2,
  parameter int DEPTH       = 4,
  parameter int SYNC_PERIOD = 64
) (
  input  logic               atclk,
  input  logic               atreset,
  input  logic               atclken,
  input  logic [DATA_W-1:0]  atdata,
  input  logic [BYTES_W-1:0] atbytes,
  input  logic [6:0]         atid,
  input  logic               atvalid,
  output logic               atready,
  output logic               afvalid,
  input  logic               afready,
  output logic               syncreq,
  input  logic               flush_req,
  output logic               flush_done,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [BYTES_W-1:0] out_bytes,
  output logic [6:0]         out_id,
  output logic               id_err,
  output logic [7:0]         id_err_cnt
);

  localparam int C_PTR_W = $clog2(DEPTH);
  localparam int C_ENT_W = DATA_W + BYTES_W + 7;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } flush_state_t;

  logic [C_ENT_W-1:0] mem_q [DEPTH];
  logic [C_PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [C_PTR_W:0]   count_q, count_d;
  logic [C_ENT_W-1:0] w_head;
  logic               w_accept, w_reserved, w_push, w_pop;
  logic               id_err_q;
  logic [7:0]         id_err_cnt_q;
  flush_state_t       state_q, state_d;
  logic               flush_done_q, flush_done_d;

  // Reserved trace IDs: 0x00, 0x70-0x7C, 0x7E, 0x7F (0x7D stays legal).
  assign w_reserved = (atid == 7'h00) ||
                      ((atid >= 7'h70) && (atid <= 7'h7C)) ||
                      (atid >= 7'h7E);

  // Readiness depends only on occupancy, so a same-cycle pop cannot raise it.
  assign atready  = !atreset && (count_q != (C_PTR_W+1)'(DEPTH));
  assign w_accept = atclken && atvalid && atready;
  assign w_push   = w_accept && !w_reserved;
  assign out_valid = (count_q != '0);
  assign w_pop     = out_valid && out_ready;

  // Show-ahead head; fields read as zero while the FIFO is empty.
  assign w_head    = mem_q[rd_ptr_q];
  assign out_data  = out_valid ? w_head[C_ENT_W-1 -: DATA_W] : '0;
  assign out_bytes = out_valid ? w_head[7 +: BYTES_W]        : '0;
  assign out_id    = out_valid ? w_head[6:0]                 : '0;

  assign id_err     = id_err_q;
  assign id_err_cnt = id_err_cnt_q;
  assign afvalid    = (state_q == FLUSH);
  assign flush_done = flush_done_q;

  // Occupancy next-state: simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    if (w_push && !w_pop)      count_d = count_q + 1'b1;
    else if (!w_push && w_pop) count_d = count_q - 1'b1;
  end

  // FIFO pointers and occupancy; reset discards all contents.
  always_ff @(posedge atclk or posedge atreset) begin
    if (atreset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // FIFO storage; contents are qualified by occupancy so no reset needed.
  always_ff @(posedge atclk) begin
    if (w_push) mem_q[wr_ptr_q] <= {atdata, atbytes, atid};
  end

  // Reserved-ID drop pulse and saturating drop counter.
  always_ff @(posedge atclk or posedge atreset) begin
    if (atreset) begin
      id_err_q     <= 1'b0;
      id_err_cnt_q <= '0;
    end else if (atclken) begin
      id_err_q <= w_accept && w_reserved;
      if (w_accept && w_reserved && (id_err_cnt_q != 8'hFF))
        id_err_cnt_q <= id_err_cnt_q + 1'b1;
    end
  end

  // Flush FSM next-state; only moves on atclken-qualified cycles.
  always_comb begin
    state_d      = state_q;
    flush_done_d = flush_done_q;
    if (atclken) begin
      flush_done_d = 1'b0;
      case (state_q)
        IDLE:  if (flush_req) state_d = FLUSH;
        FLUSH: if (afready) begin
                 state_d      = IDLE;
                 flush_done_d = 1'b1;
               end
        default: state_d = IDLE;
      endcase
    end
  end

  // Flush FSM state register.
  always_ff @(posedge atclk or posedge atreset) begin
    if (atreset) begin
      state_q      <= IDLE;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_done_q <= flush_done_d;
    end
  end

  generate
    if (SYNC_PERIOD > 0) begin : g_sync
      localparam int C_SYNC_W = (SYNC_PERIOD > 1) ? $clog2(SYNC_PERIOD + 1) : 1;
      logic [C_SYNC_W-1:0] sync_cnt_q;
      logic                syncreq_q;

      // Count every accepted beat; pulse syncreq and clear on reaching the period.
      always_ff @(posedge atclk or posedge atreset) begin
        if (atreset) begin
          sync_cnt_q <= '0;
          syncreq_q  <= 1'b0;
        end else if (atclken) begin
          syncreq_q <= 1'b0;
          if (w_accept) begin
            if (sync_cnt_q + 1'b1 == C_SYNC_W'(SYNC_PERIOD)) begin
              sync_cnt_q <= '0;
              syncreq_q  <= 1'b1;
            end else begin
              sync_cnt_q <= sync_cnt_q + 1'b1;
            end
          end
        end
      end

      assign syncreq = syncreq_q;
    end else begin : g_nosync
      assign syncreq = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_atb_sink.sv
`default_nettype none
// ============================================================================
// Module   : tb_atb_sink
// Brief    : Directed self-checking bench for atb_sink (DEPTH=4, SYNC_PERIOD=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_atb_sink;

  logic        atclk = 1'b0;
  logic        atreset, atclken, atvalid, afready, flush_req, out_ready;
  logic [31:0] atdata;
  logic [1:0]  atbytes;
  logic [6:0]  atid;
  logic        atready, afvalid, syncreq, flush_done, out_valid, id_err;
  logic [31:0] out_data;
  logic [1:0]  out_bytes;
  logic [6:0]  out_id;
  logic [7:0]  id_err_cnt;

  int errors = 0;
  int checks = 0;

  always #5 atclk = ~atclk;

  atb_sink #(.DATA_W(32), .BYTES_W(2), .DEPTH(4), .SYNC_PERIOD(4)) dut (
    .atclk(atclk), .atreset(atreset), .atclken(atclken),
    .atdata(atdata), .atbytes(atbytes), .atid(atid),
    .atvalid(atvalid), .atready(atready),
    .afvalid(afvalid), .afready(afready), .syncreq(syncreq),
    .flush_req(flush_req), .flush_done(flush_done),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_bytes(out_bytes), .out_id(out_id),
    .id_err(id_err), .id_err_cnt(id_err_cnt)
  );

  task automatic tick();
    @(posedge atclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a beat whose data and byte count are derived from the ID.
  task automatic drive_beat(input logic [6:0] id);
    atvalid = 1'b1;
    atid    = id;
    atdata  = {25'h0ABCDE0, id};
    atbytes = id[1:0];
  endtask

  logic [6:0] rsv_ids [7];
  logic       rsv_exp [7];

  initial begin
    rsv_ids = '{7'h00, 7'h70, 7'h7C, 7'h7E, 7'h7F, 7'h7D, 7'h6F};
    rsv_exp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    atreset = 1'b1; atclken = 1'b1; atvalid = 1'b0; afready = 1'b0;
    flush_req = 1'b0; out_ready = 1'b0; atdata = '0; atbytes = '0; atid = '0;
    tick(); tick();

    // Reset values
    check("rst_atready", atready, 0);
    check("rst_afvalid", afvalid, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_id", out_id, 0);
    check("rst_id_err_cnt", id_err_cnt, 0);
    check("rst_syncreq", syncreq, 0);
    atreset = 1'b0;
    #1;
    check("rel_atready", atready, 1);

    // Fill the FIFO with 0x10..0x13
    for (int i = 0; i < 4; i++) begin
      drive_beat(7'(8'h10 + i));
      tick();
    end
    check("full_atready", atready, 0);
    check("full_out_id", out_id, 7'h10);
    check("full_out_data", out_data, 32'h0ABCDE0 << 7 | 32'h10);
    atvalid = 1'b0;
    out_ready = 1'b1;
    #1;
    check("pop_same_cycle_atready", atready, 0);
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", out_valid, 1);
      check("drain_id", out_id, 7'(8'h10 + i));
      tick();
      if (i == 0) check("atready_after_pop", atready, 1);
    end
    check("drain_empty", out_valid, 0);
    check("empty_out_id", out_id, 0);
    out_ready = 1'b0;

    // Reserved ID filtering
    for (int i = 0; i < 7; i++) begin
      drive_beat(rsv_ids[i]);
      tick();
      check("id_err_pulse", id_err, rsv_exp[i]);
    end
    atvalid = 1'b0;
    tick();
    check("id_err_clear", id_err, 0);
    check("id_err_cnt5", id_err_cnt, 5);
    check("rsv_head_7d", out_id, 7'h7D);
    out_ready = 1'b1;
    tick();
    check("rsv_head_6f", out_id, 7'h6F);
    tick();
    check("rsv_empty", out_valid, 0);
    out_ready = 1'b0;
    drive_beat(7'h00);
    for (int i = 0; i < 300; i++) tick();
    atvalid = 1'b0;
    tick();
    check("id_err_cnt_sat", id_err_cnt, 255);
    check("rsv_no_write", out_valid, 0);

    // Flush handshake
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    check("flush_afvalid", afvalid, 1);
    for (int i = 0; i < 3; i++) begin
      flush_req = (i == 0);
      tick();
      check("flush_hold", afvalid, 1);
    end
    flush_req = 1'b0;
    afready = 1'b1;
    tick();
    check("flush_end_afvalid", afvalid, 0);
    check("flush_done_pulse", flush_done, 1);
    tick();
    check("flush_done_clear", flush_done, 0);
    check("no_requeued_flush", afvalid, 0);
    tick();
    check("afready_idle_ignored", afvalid, 0);
    check("afready_idle_done", flush_done, 0);
    afready = 1'b0;

    // Sync requests after 4th and 8th accepts
    atreset = 1'b1;
    tick();
    atreset = 1'b0;
    out_ready = 1'b1;
    drive_beat(7'h20);
    for (int k = 1; k <= 9; k++) begin
      tick();
      check("syncreq", syncreq, (k == 4 || k == 8) ? 1 : 0);
    end
    atvalid = 1'b0;
    tick();
    check("sync_after", syncreq, 0);
    tick();
    check("sync_drained", out_valid, 0);
    out_ready = 1'b0;

    // Clock-enable low: no writes or FSM change, pops still proceed
    drive_beat(7'h30); tick();
    drive_beat(7'h31); tick();
    atclken = 1'b0; drive_beat(7'h40); flush_req = 1'b1; out_ready = 1'b1;
    tick();
    check("clken_pop1", out_id, 7'h31);
    check("clken_afvalid", afvalid, 0);
    tick();
    check("clken_pop2", out_valid, 0);
    tick();
    check("clken_no_write", out_valid, 0);
    check("clken_afvalid3", afvalid, 0);
    atclken = 1'b1; flush_req = 1'b0; atvalid = 1'b0; out_ready = 1'b0;

    // Full FIFO with continuous push and pop: order preserved
    for (int i = 0; i < 4; i++) begin
      drive_beat(7'(8'h50 + i));
      tick();
    end
    check("stream_full", atready, 0);
    out_ready = 1'b1;
    drive_beat(7'h54);
    tick();
    check("stream_head1", out_id, 7'h51);
    check("stream_ready1", atready, 1);
    tick();
    check("stream_head2", out_id, 7'h52);
    drive_beat(7'h55); tick();
    check("stream_head3", out_id, 7'h53);
    drive_beat(7'h56); tick();
    check("stream_head4", out_id, 7'h54);
    check("stream_ready4", atready, 1);
    atvalid = 1'b0;
    tick();
    check("stream_head5", out_id, 7'h55);
    tick();
    check("stream_head6", out_id, 7'h56);
    tick();
    check("stream_empty", out_valid, 0);
    out_ready = 1'b0;

    // Asynchronous reset while flushing with two entries queued
    flush_req = 1'b1; tick(); flush_req = 1'b0;
    drive_beat(7'h60); tick();
    drive_beat(7'h61); tick();
    atvalid = 1'b0;
    check("pre_rst_afvalid", afvalid, 1);
    check("pre_rst_out_id", out_id, 7'h60);
    #2;
    atreset = 1'b1;
    #1;
    check("async_afvalid", afvalid, 0);
    check("async_out_valid", out_valid, 0);
    check("async_atready", atready, 0);
    tick();
    atreset = 1'b0;
    #1;
    check("post_rst_atready", atready, 1);
    check("post_rst_empty", out_valid, 0);
    check("post_rst_cnt", id_err_cnt, 0);
    tick();
    check("post_rst_afvalid", afvalid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
